// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM family: read-during-write mode codes,
// the clear-sequencer state type and an elaboration-time clog2.
package bram_pkg;

  localparam int RD_MODE_READ_FIRST  = 0;
  localparam int RD_MODE_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_e;

  // Ceiling log2 for sizing counters and address fields; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset memory clear sequencer: walks every address once writing zeros,
// holding busy high until the last word has been written.
module bram_clear_seq
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

  clear_state_e     state_reg, state_next;
  logic [CNT_W-1:0] addr_reg, addr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  // The counter parks on the last address so there is never a second pass.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    if (state_reg == CLEAR) begin
      if (addr_reg == LAST_ADDR) begin
        state_next = READY;
      end else begin
        addr_next = addr_reg + 1'b1;
      end
    end
  end

  assign busy     = (state_reg == CLEAR);
  assign clr_we   = busy & ~rst;
  assign clr_addr = ADDR_WIDTH'(addr_reg);

endmodule

// File: rtl/bram_sync_sdp.sv
// Simple-dual-port synchronous BRAM with byte enables, selectable collision
// mode and optional output register. Define BRAM_SYNC_SDP_CLEAR_EN for the post-reset clear.
module bram_sync_sdp
  import bram_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_MODE        = 0,
  parameter int OUT_REG        = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [RAM_ADDR_WIDTH-1:0]            wr_addr,
  input  logic [RAM_DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [RAM_DATA_WIDTH-1:0]            wr_data,
  input  logic                                 rd_en,
  input  logic [RAM_ADDR_WIDTH-1:0]            rd_addr,
  output logic [RAM_DATA_WIDTH-1:0]            rd_data,
  output logic                                 rd_valid,
  output logic                                 busy
);

  localparam int DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int LANES = RAM_DATA_WIDTH / BYTE_WIDTH;

  generate
    if (RAM_DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("bram_sync_sdp: RAM_DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_MODE != RD_MODE_READ_FIRST && RD_MODE != RD_MODE_WRITE_FIRST) begin : g_bad_mode
      $error("bram_sync_sdp: RD_MODE must be 0 or 1");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_outreg
      $error("bram_sync_sdp: OUT_REG must be 0 or 1");
    end
  endgenerate

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

  logic                      mem_we;
  logic [RAM_ADDR_WIDTH-1:0] mem_addr;
  logic [LANES-1:0]          mem_be;
  logic [RAM_DATA_WIDTH-1:0] mem_din;
  logic                      rd_go;

`ifdef BRAM_SYNC_SDP_CLEAR_EN
  logic                      clr_we;
  logic [RAM_ADDR_WIDTH-1:0] clr_addr;

  bram_clear_seq #(
    .ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The sequencer owns the write port while clearing; user strobes are dropped.
  assign mem_we   = clr_we | (wr_en & ~busy);
  assign mem_addr = clr_we ? clr_addr : wr_addr;
  assign mem_be   = clr_we ? {LANES{1'b1}} : wr_be;
  assign mem_din  = clr_we ? '0 : wr_data;
`else
  assign busy     = 1'b0;
  assign mem_we   = wr_en;
  assign mem_addr = wr_addr;
  assign mem_be   = wr_be;
  assign mem_din  = wr_data;
`endif

  assign rd_go = rd_en & ~busy;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [RAM_DATA_WIDTH-1:0] rd_old;
  logic [RAM_DATA_WIDTH-1:0] rd_word;
  logic                      rd_hit;

  assign rd_old = mem[rd_addr];
  assign rd_hit = mem_we && (mem_addr == rd_addr);

  // Write-first forwards only the enabled lanes; the rest come from the stored word.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (RD_MODE == RD_MODE_WRITE_FIRST) begin : g_wf
        assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = (rd_hit && mem_be[gi])
            ? mem_din[gi*BYTE_WIDTH +: BYTE_WIDTH]
            : rd_old[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin : g_rf
        assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = rd_old[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  endgenerate

  logic                      s1_valid_reg;
  logic [RAM_DATA_WIDTH-1:0] s1_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_go;
      if (rd_go) begin
        s1_data_reg <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic                      s2_valid_reg;
      logic [RAM_DATA_WIDTH-1:0] s2_data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_reg <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign rd_data  = s2_data_reg;
      assign rd_valid = s2_valid_reg;
    end else begin : g_no_out_reg
      assign rd_data  = s1_data_reg;
      assign rd_valid = s1_valid_reg;
    end
  endgenerate

endmodule

// File: doc/bram_sync_sdp.md
# bram_sync_sdp

Parametrised simple-dual-port synchronous block RAM: one write port and one independent read port on a single clock. It generalises the single-port BRAM with:
- per-byte write enables;
- a selectable read-during-write mode;
- an optional output pipeline register;
- a read-valid strobe;
- an optional post-reset memory-clear sequencer.

It is the storage primitive for FIFOs, delay lines and packet buffers in the library.

## Interface
- RAM_DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- RAM_ADDR_WIDTH, 4, address width; depth = 2**RAM_ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; set equal to RAM_DATA_WIDTH for one enable.
- RD_MODE, 0, same-address collision: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 1 adds an output register stage.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  RAM_ADDR_WIDTH  write address.
- wr_be  in  RAM_DATA_WIDTH/BYTE_WIDTH  byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_data  in  RAM_DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  RAM_ADDR_WIDTH  read address.
- rd_data  out  RAM_DATA_WIDTH  read data, held between reads.
- rd_valid  out  1  one-cycle pulse marking a new rd_data.
- busy  out  1  clear sequencer active; both ports ignored.

## Operation
- Write: on a clk edge with wr_en=1 and busy=0, each lane with wr_be[i]=1 is updated. Lanes with wr_be[i]=0 keep their contents. wr_en=1 with wr_be=0 is a no-op.
- Read: on a clk edge with rd_en=1 and busy=0, the word at rd_addr is fetched. rd_data updates and rd_valid pulses after the latency below.
- When no read completes, rd_data holds its last value and rd_valid=0.
- Collision (rd_en, wr_en, rd_addr==wr_addr, same cycle):
  - RD_MODE=0 returns the pre-write word.
  - RD_MODE=1 returns the merged word: enabled lanes from wr_data, other lanes from the old word.
- Memory contents are not affected by rst unless the clear feature is compiled in.
- Elaboration fails if RAM_DATA_WIDTH % BYTE_WIDTH != 0 or RD_MODE/OUT_REG are not 0/1.

## Timing
- Read latency is 1 + OUT_REG cycles from the rd_en edge to rd_data/rd_valid.
- Fully pipelined: one read and one write accepted every cycle.
- Write-to-read, different cycles: a read issued the cycle after a write returns the new data.
- Reset values: rd_data=0, rd_valid=0, and every pipeline stage valid bit = 0.
- busy reset value: 1 with the clear feature, constant 0 without it.
- rst asserted mid-read: the in-flight read is dropped and no rd_valid is emitted.

## Configuration
- Macro: BRAM_SYNC_SDP_CLEAR_EN.
- Defined: clear sequencer with states CLEAR and READY.
  - rst forces CLEAR with the address counter at 0.
  - After rst deasserts, one word of zeros is written per cycle to addresses 0..2**RAM_ADDR_WIDTH-1.
  - After the last address is written, the sequencer moves to READY and busy falls in the following cycle.
  - Total busy time is 2**RAM_ADDR_WIDTH cycles after rst falls.
  - wr_en/rd_en are ignored while busy; the counter does not wrap into a second pass.
  - rst during CLEAR restarts the sequence at address 0.
- Undefined: no sequencer, busy tied 0, ports live on the first edge after rst falls, and initial contents are undefined (X in simulation).

## Structure
- Shared package bram_pkg holds:
  - RD_MODE_READ_FIRST=0 and RD_MODE_WRITE_FIRST=1 constants;
  - the clear-state enum type;
  - a clog2 helper used by the BRAM family.
- Sub-module bram_clear_seq: FSM plus address counter, outputs busy, clr_we and clr_addr. It is instantiated only under BRAM_SYNC_SDP_CLEAR_EN.
- The memory array and read path stay in bram_sync_sdp so synthesis infers block RAM.

## Test plan
Defaults: DW=32, AW=4, BYTE=8.
- Write 0xDEADBEEF @3 with be=4'hF, then read @3 next cycle -> rd_data=0xDEADBEEF with rd_valid one cycle after rd_en (two cycles with OUT_REG=1).
- Over 0xDEADBEEF @3, write 0x11223344 with be=4'b0101 -> readback 0xDE22BE44.
- Collision @5 (old 0xAAAAAAAA, write 0x55555555, be=4'hF) -> RD_MODE=0 returns 0xAAAAAAAA, RD_MODE=1 returns 0x55555555.
- Back-to-back reads @0..15 after filling with address*0x01010101 -> 16 consecutive rd_valid pulses with matching data and no gaps.
- CLEAR_EN: fill memory with 0xFFFFFFFF, pulse rst, and check:
  - busy stays high 16 cycles after rst falls;
  - a rd_en issued while busy yields no rd_valid;
  - all addresses then read 0.
- CLEAR_EN: reassert rst at clear address 7 -> busy persists a full 16 cycles after the second rst falls. Read in-flight at rst -> no rd_valid.
